// File: rtl/seq_udiv_unit.sv
// Multi-cycle unsigned divider: restoring shift-and-subtract, one quotient bit per clock.
// Results appear only on the done cycle and are held until the next accepted start.
module seq_udiv_unit #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   // state  | meaning
   // S_IDLE | waiting for start; outputs hold the last result
   // S_RUN  | one shift-and-subtract step per clock, counter counts down
   // S_FIN  | done pulse; quotient/remainder/div_by_zero valid
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] dq;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] rem_p;
   logic [CNT_W-1:0] cnt;

   logic             accept;
   logic             accept_zero;
   logic             last_iter;
   logic [WIDTH:0]   r_shift;
   logic             ge;
   logic [WIDTH-1:0] r_sub;
   logic [WIDTH-1:0] r_nxt;
   logic [WIDTH-1:0] dq_nxt;

   // The quotient bits enter dq from the bottom as dividend bits leave the top.
   // r_shift[WIDTH] set means r' already exceeds any WIDTH-bit divisor, so the
   // low-half subtraction alone yields the exact (< divisor) result.
   always_comb begin
      r_shift = {rem_p, dq[WIDTH-1]};
      ge      = r_shift[WIDTH] | (r_shift[WIDTH-1:0] >= dsr);
      r_sub   = r_shift[WIDTH-1:0] - dsr;
      r_nxt   = ge ? r_sub : r_shift[WIDTH-1:0];
      dq_nxt  = {dq[WIDTH-2:0], ge};
   end

   assign last_iter = (cnt == CNT_W'(1));

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      accept_zero = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (divisor == '0) begin
                  accept_zero = 1'b1;
                  state_nxt   = S_FIN;
               end else begin
                  state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (last_iter) state_nxt = S_FIN;
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dq    <= '0;
         dsr   <= '0;
         rem_p <= '0;
         cnt   <= '0;
      end else if (accept) begin
         dq    <= dividend;
         dsr   <= divisor;
         rem_p <= '0;
         cnt   <= accept_zero ? '0 : CNT_W'(WIDTH);
      end else if (state == S_RUN) begin
         dq    <= dq_nxt;
         rem_p <= r_nxt;
         cnt   <= cnt - CNT_W'(1);
      end
   end

   // Visible results change only on the edge that enters S_FIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept_zero) begin
         quotient    <= '0;
         remainder   <= dividend;
         div_by_zero <= 1'b1;
      end else if (state == S_RUN && last_iter) begin
         quotient    <= dq_nxt;
         remainder   <= r_nxt;
         div_by_zero <= 1'b0;
      end
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_FIN);

endmodule

// File: tb/tb_seq_udiv_unit.sv
// Bench for seq_udiv_unit: an 8-bit and a 64-bit instance checked against
// plain / and % arithmetic with directed and random operands.
module tb_seq_udiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        wide_sel;
   logic [63:0] op_a;
   logic [63:0] op_b;

   logic        busy8, done8, dbz8;
   logic [7:0]  q8, r8;
   logic        busy64, done64, dbz64;
   logic [63:0] q64, r64;

   logic        v_busy, v_done, v_dbz;
   logic [63:0] v_q, v_r;

   int n_checks;
   int n_errors;

   seq_udiv_unit #(.WIDTH(8), .CNT_W(4)) u_div8 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start & ~wide_sel),
      .dividend    (op_a[7:0]),
      .divisor     (op_b[7:0]),
      .busy        (busy8),
      .done        (done8),
      .quotient    (q8),
      .remainder   (r8),
      .div_by_zero (dbz8)
   );

   seq_udiv_unit #(.WIDTH(64), .CNT_W(7)) u_div64 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start & wide_sel),
      .dividend    (op_a),
      .divisor     (op_b),
      .busy        (busy64),
      .done        (done64),
      .quotient    (q64),
      .remainder   (r64),
      .div_by_zero (dbz64)
   );

   assign v_busy = wide_sel ? busy64 : busy8;
   assign v_done = wide_sel ? done64 : done8;
   assign v_dbz  = wide_sel ? dbz64  : dbz8;
   assign v_q    = wide_sel ? q64 : {56'd0, q8};
   assign v_r    = wide_sel ? r64 : {56'd0, r8};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One division on the selected instance; checks latency, busy length,
   // results, FIN-cycle start rejection and result hold.
   task automatic run_op(input bit wide, input logic [63:0] a_in, input logic [63:0] b_in,
                         input bit mid_start);
      logic [63:0] a, b, eq, er;
      logic        edbz;
      int          w, edges, busy_cnt;
      w = wide ? 64 : 8;
      a = wide ? a_in : (a_in & 64'hFF);
      b = wide ? b_in : (b_in & 64'hFF);
      if (b == 0) begin
         eq = 0; er = a; edbz = 1'b1;
      end else begin
         eq = a / b; er = a % b; edbz = 1'b0;
      end

      @(negedge clk);
      wide_sel = wide;
      op_a     = a;
      op_b     = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      op_a     = {$urandom, $urandom};
      op_b     = {$urandom, $urandom};
      edges    = 1;
      busy_cnt = 0;
      while (!v_done && edges < w + 10) begin
         if (v_busy) busy_cnt++;
         if (mid_start && edges == 3) begin
            op_a  = {$urandom, $urandom};
            op_b  = {$urandom, $urandom};
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         edges++;
      end
      start = 1'b0;
      chk("latency", 64'(edges), (b == 0) ? 64'd1 : 64'(w + 1));
      chk("busy_cycles", 64'(busy_cnt), (b == 0) ? 64'd0 : 64'(w));
      chk("done", {63'd0, v_done}, 64'd1);
      chk("busy_at_done", {63'd0, v_busy}, 64'd0);
      chk("quotient", v_q, eq);
      chk("remainder", v_r, er);
      chk("div_by_zero", {63'd0, v_dbz}, {63'd0, edbz});

      // start during FIN must not be taken
      op_a  = 64'd77;
      op_b  = 64'd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("fin_start_busy", {63'd0, v_busy}, 64'd0);
      chk("fin_start_done", {63'd0, v_done}, 64'd0);
      chk("hold_quotient", v_q, eq);
      chk("hold_remainder", v_r, er);
      chk("hold_dbz", {63'd0, v_dbz}, {63'd0, edbz});
   endtask

   task automatic reset_mid_run();
      int done_seen;
      @(negedge clk);
      wide_sel = 1'b0;
      op_a     = 64'd200;
      op_b     = 64'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", {63'd0, busy8}, 64'd0);
      chk("rst_done", {63'd0, done8}, 64'd0);
      chk("rst_q", {56'd0, q8}, 64'd0);
      chk("rst_r", {56'd0, r8}, 64'd0);
      chk("rst_dbz", {63'd0, dbz8}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done8 || busy8) done_seen++;
      end
      chk("no_done_after_rst", 64'(done_seen), 64'd0);
      run_op(1'b0, 64'd200, 64'd3, 1'b0);
   endtask

   initial begin
      logic [63:0] a, b;
      int          mode;
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      wide_sel = 1'b0;
      op_a     = '0;
      op_b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy8", {63'd0, busy8}, 64'd0);
      chk("reset_done8", {63'd0, done8}, 64'd0);
      chk("reset_q8", {56'd0, q8}, 64'd0);
      chk("reset_r64", r64, 64'd0);
      chk("reset_dbz64", {63'd0, dbz64}, 64'd0);
      rst_n = 1'b1;

      run_op(1'b0, 64'd100, 64'd7, 1'b0);
      run_op(1'b0, 64'h2A, 64'd0, 1'b0);
      run_op(1'b0, 64'd255, 64'd255, 1'b0);
      run_op(1'b0, 64'd5, 64'd200, 1'b0);
      run_op(1'b0, 64'd250, 64'd129, 1'b0);
      run_op(1'b0, 64'd100, 64'd7, 1'b1);
      reset_mid_run();

      run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0001, 1'b0);
      run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);
      run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      run_op(1'b1, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0);
      run_op(1'b1, 64'h0123_4567_89AB_CDEF, 64'd10, 1'b1);

      for (int i = 0; i < 40; i++) begin
         a = 64'($urandom_range(0, 255));
         b = (i % 8 == 0) ? 64'd0 : 64'($urandom_range(0, 255));
         run_op(1'b0, a, b, (i % 5 == 0));
      end

      for (int i = 0; i < 16; i++) begin
         a    = {$urandom, $urandom};
         mode = i % 4;
         case (mode)
            0:       b = 64'($urandom_range(1, 1000));
            1:       b = {1'b1, 31'($urandom), $urandom};
            2:       b = {32'd0, $urandom};
            default: b = {$urandom, $urandom};
         endcase
         if (i == 7) b = 64'd0;
         run_op(1'b1, a, b, (i % 3 == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
